// File: rtl/instr_fetch_pkg.sv
// Shared configuration header for the multi-cycle datapath: opcode/func
// encodings, controller states, IR field positions, NOP and fetch FSM states.
package instr_fetch_pkg;

  // Existing opcode encodings
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Existing R-type func encodings
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Existing main-controller states
  typedef enum logic [2:0] {
    C_FETCH, C_DECODE, C_EXEC, C_MEM, C_WB, C_PCUPD
  } ctrl_state_e;

  // IR field bit positions
  localparam int IR_OP_HI  = 31;
  localparam int IR_OP_LO  = 26;
  localparam int IR_RS_HI  = 25;
  localparam int IR_RS_LO  = 21;
  localparam int IR_RT_HI  = 20;
  localparam int IR_RT_LO  = 16;
  localparam int IR_RD_HI  = 15;
  localparam int IR_RD_LO  = 11;
  localparam int IR_FN_HI  = 5;
  localparam int IR_FN_LO  = 0;
  localparam int IR_IMM_HI = 15;
  localparam int IR_IMM_LO = 0;

  // Instruction loaded into the IR when a fetch is aborted
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IF_IDLE, IF_WAIT, IF_ABORT
  } ifetch_state_e;

  // Sequential or branch successor of a PC; +4 wraps modulo 2^32
  function automatic logic [31:0] next_pc(input logic [31:0] cur,
                                          input logic        src,
                                          input logic [31:0] tgt);
    return src ? tgt : cur + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_timer.sv
// Fetch timeout counter. Counts enabled cycles since the last clear; expired
// is high during the LIMIT-th enabled cycle, i.e. the last one allowed.
module ifetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  // Count enabled cycles, saturating at the last allowed cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= 8'd0;
    else if (clear)             cnt <= 8'd0;
    else if (enable && !expired) cnt <= cnt + 8'd1;
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, IR, and an IDLE/WAIT/ABORT fetch FSM
// talking to an ack-based instruction memory with a timeout.
// Optional build macro IFETCH_ALIGN_CHECK_EN: a misaligned PC aborts the
// fetch without touching memory. Without it the low address bits are forced
// to zero and no alignment error exists.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_inc,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);

  ifetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  // single pending PC-update slot, filled while a fetch is outstanding
  logic        pend_q, pend_d;
  logic        pend_src_q, pend_src_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  // fetch held back one cycle because a PC update arrived with it
  logic        defer_q, defer_d;

  logic        fetch_go;
  logic [31:0] pc_mid, pc_done;
  logic        tmr_clr, tmr_en, tmr_expired;

  assign tmr_en  = (state_q == IF_WAIT);
  assign tmr_clr = (state_q != IF_WAIT);

  ifetch_timer #(.LIMIT(IMEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // PC at fetch completion: pending update first, then any strobe arriving now
  assign pc_mid   = pend_q ? next_pc(pc_q, pend_src_q, pend_tgt_q) : pc_q;
  assign pc_done  = pc_inc ? next_pc(pc_mid, pcsrc, branch_target) : pc_mid;
  assign fetch_go = fetch_req | defer_q;

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IF_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    vld_d      = vld_q;
    busy_d     = busy_q;
    err_d      = err_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    defer_d    = 1'b0;
    case (state_q)
      IF_IDLE: begin
        if (pc_inc) begin
          // PC update wins; a simultaneous fetch goes out next cycle at new PC
          pc_d    = next_pc(pc_q, pcsrc, branch_target);
          defer_d = fetch_go;
        end else if (fetch_go) begin
          busy_d = 1'b1;
          vld_d  = 1'b0;
          err_d  = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (pc_q[1:0] != 2'b00) begin
            state_d = IF_ABORT;
            err_d   = 1'b1;
            ir_d    = NOP;
          end else begin
            state_d = IF_WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
`else
          state_d = IF_WAIT;
          req_d   = 1'b1;
          addr_d  = {pc_q[31:2], 2'b00};
`endif
        end
      end
      IF_WAIT: begin
        if (imem_ack) begin
          state_d = IF_IDLE;
          ir_d    = imem_rdata;
          vld_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          pc_d    = pc_done;
          pend_d  = 1'b0;
        end else begin
          if (pc_inc) begin
            pend_d     = 1'b1;
            pend_src_d = pcsrc;
            pend_tgt_d = branch_target;
          end
          if (tmr_expired) begin
            state_d = IF_ABORT;
            req_d   = 1'b0;
            ir_d    = NOP;
            err_d   = 1'b1;
          end
        end
      end
      IF_ABORT: begin
        state_d = IF_IDLE;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        pc_d    = pc_done;
        pend_d  = 1'b0;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // Datapath registers; reset drops any fetch in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pend_q     <= 1'b0;
      pend_src_q <= 1'b0;
      pend_tgt_q <= 32'h0;
      defer_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
      defer_q    <= defer_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = ir_q;
  assign instr_valid = vld_q;
  assign busy        = busy_q;
  assign fetch_err   = err_q;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;

  assign opcode = ir_q[IR_OP_HI:IR_OP_LO];
  assign rs     = ir_q[IR_RS_HI:IR_RS_LO];
  assign rt     = ir_q[IR_RT_HI:IR_RT_LO];
  assign rd     = ir_q[IR_RD_HI:IR_RD_LO];
  assign func   = ir_q[IR_FN_HI:IR_FN_LO];
  assign imm    = ir_q[IR_IMM_HI:IR_IMM_LO];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 15, is the maximum number of cycles to wait for imem_ack before aborting a fetch (legal range 1..255).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 fetch_req  in  1  one-cycle strobe from the controller's fetch state requesting the instruction at pc.
REQ-006 pc_inc  in  1  one-cycle strobe from the controller's PC-update state.
REQ-007 pcsrc  in  1  selects the next PC when pc_inc is sampled: 0 = pc_plus4, 1 = branch_target.
REQ-008 branch_target  in  32  branch destination computed by the ALU.
REQ-009 imem_req  out  1  instruction-memory read request.
REQ-010 imem_addr  out  32  instruction-memory byte address.
REQ-011 imem_ack  in  1  read-data-valid strobe from memory.
REQ-012 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-013 pc, pc_plus4  out  32 each  current PC and pc+4.
REQ-014 instr  out  32  instruction register (IR).
REQ-015 opcode[5:0], func[5:0], rs[4:0], rt[4:0], rd[4:0], imm[15:0]  out  decoded IR fields.
REQ-016 instr_valid  out  1  IR holds a completed fetch.
REQ-017 busy  out  1  fetch in progress.
REQ-018 fetch_err  out  1  last fetch aborted.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT and ABORT.
REQ-020 IDLE + fetch_req: next cycle imem_req=1, imem_addr=pc, busy=1, instr_valid=0, fetch_err=0, state WAIT, timeout counter cleared.
REQ-021 WAIT: imem_req and imem_addr SHALL be held stable until the cycle in which imem_ack=1 is sampled.
REQ-022 WAIT + imem_ack: IR<=imem_rdata, instr_valid=1, imem_req=0, busy=0 on the next cycle; state IDLE. Fetch latency is therefore ack cycle + 1.
REQ-023 WAIT, counter reaches IMEM_TIMEOUT without ack: state ABORT for one cycle (imem_req=0, IR<=NOP 32'h0, fetch_err=1), then IDLE with instr_valid=1.
REQ-024 imem_ack sampled in IDLE or ABORT SHALL be ignored.
REQ-025 fetch_req while busy SHALL be ignored.
REQ-026 pc_inc in IDLE: pc <= pcsrc ? branch_target : pc+4 on the next edge.
REQ-027 pc_inc while busy: the strobe and pcsrc/branch_target SHALL be captured in a single pending slot and applied in the cycle the fetch completes (ack or abort).
REQ-028 fetch_req and pc_inc in the same IDLE cycle: the PC updates first; the fetch is issued one cycle later at the new PC.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 The decoded field outputs SHALL be combinational slices of the IR: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0], imm=[15:0].

Reset
REQ-031 Reset asserted: pc=RESET_PC, IR=0, instr_valid=0, busy=0, fetch_err=0, imem_req=0, imem_addr=RESET_PC, pending slot cleared, state IDLE, asynchronously and regardless of any fetch in flight.
REQ-032 Reset mid-fetch: the outstanding request SHALL be dropped; a late imem_ack after reset release SHALL be ignored per REQ-024.

Configuration
REQ-033 With IFETCH_ALIGN_CHECK_EN defined, fetch_req with pc[1:0]!=0 SHALL skip memory (imem_req stays 0) and go directly to ABORT (fetch_err=1, IR=NOP).
REQ-034 Without IFETCH_ALIGN_CHECK_EN, imem_addr[1:0] SHALL be forced to 2'b00 and no alignment error SHALL be raised.

Structure
REQ-035 The shared configuration header SHALL hold the IR field bit positions, the NOP constant and the fetch FSM state encodings, alongside the existing opcode/func/state definitions.
REQ-036 The timeout counter SHALL be a sub-module ifetch_timer with inputs clear and enable, a parameterized limit, and output expired.

Verification
REQ-037 Reset release, fetch_req, ack after 2 cycles with data 32'h012A4020 -> imem_addr=0; instr=32'h012A4020, opcode=0, func=6'h20, rd=8, instr_valid=1.
REQ-038 pc=32'h100, pcsrc=1, branch_target=32'h40, pc_inc -> pc=32'h40 next cycle; next fetch drives imem_addr=32'h40.
REQ-039 fetch_req with no ack, IMEM_TIMEOUT=15 -> ABORT entered after 15 WAIT cycles; fetch_err=1, instr=0, imem_req low.
REQ-040 pc_inc (pcsrc=0) during WAIT at pc=32'h8 -> pc stays 32'h8 until ack; pc=32'hC in the ack-completion cycle.
REQ-041 pc=32'hFFFF_FFFC, pc_inc with pcsrc=0 -> pc=0; reset pulsed mid-WAIT -> pc=RESET_PC, busy=0, subsequent stray ack ignored.
REQ-042 With IFETCH_ALIGN_CHECK_EN and branch to 32'h42, then fetch_req -> imem_req never asserts; fetch_err=1.
